// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared types and constants for the instruction-cycle sequencer
package cpu_seq_pkg;

  // Opcode width shared with the instruction decoder
  localparam int OPC_WIDTH = 4;

  // Halt opcode: entering STOP is absorbing until reset
  localparam logic [OPC_WIDTH-1:0] OP_STP = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_STOP
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones, with clear taking priority
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // Clear wins over increment; increment stops once the counter is full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction-cycle sequencer with run/step, PC breakpoint and counters
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RUN,
  input  logic                 STEP,
  input  logic                 EXTRA,
  input  logic [OPC_WIDTH-1:0] IR,
  input  logic [PC_WIDTH-1:0]  PC,
  input  logic                 BP_EN,
  input  logic [PC_WIDTH-1:0]  BP_ADDR,
  input  logic                 CLR_CNT,
  output logic                 FETCH,
  output logic                 EXEC1,
  output logic                 EXEC2,
  output logic                 HALTED,
  output logic                 STOPPED,
  output logic                 BP_HIT,
  output logic [CNT_WIDTH-1:0] CYCLE_CNT,
  output logic [CNT_WIDTH-1:0] INSTR_CNT
);

  seq_state_t state, state_n;
  logic       step_d, step_req;
  logic       step_mode, step_mode_n;
  logic       resume, resume_n;
  logic       bp_hit, bp_hit_n;
  logic       instr_end, instr_done;
  logic       bp_match;

  assign bp_match = BP_EN && (PC == BP_ADDR);

  // STEP edge detect; the request is registered so it lands one cycle after the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_d   <= 1'b0;
      step_req <= 1'b0;
    end else begin
      step_d   <= STEP;
      step_req <= STEP & ~step_d;
    end
  end

  // State register and debug flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      step_mode <= 1'b0;
      resume    <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      state     <= state_n;
      step_mode <= step_mode_n;
      resume    <= resume_n;
      bp_hit    <= bp_hit_n;
    end
  end

  // Next-state and flag updates; resume lets the FETCH right after a halt pass the breakpoint
  always_comb begin
    state_n     = state;
    step_mode_n = step_mode;
    resume_n    = resume;
    bp_hit_n    = bp_hit;
    instr_end   = 1'b0;
    instr_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (RUN || step_req) begin
          state_n  = S_FETCH;
          resume_n = 1'b1;
          bp_hit_n = 1'b0;
          if (!RUN) begin
            step_mode_n = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (bp_match && !resume) begin
          state_n  = S_IDLE;
          bp_hit_n = 1'b1;
        end else begin
          state_n  = S_EXEC1;
          resume_n = 1'b0;
        end
      end
      S_EXEC1: begin
        if (IR == OP_STP) begin
          state_n    = S_STOP;
          instr_done = 1'b1;
        end else if (EXTRA) begin
          state_n = S_EXEC2;
        end else begin
          instr_end = 1'b1;
        end
      end
      S_EXEC2: instr_end = 1'b1;
      S_STOP:  state_n = S_STOP;
      default: state_n = S_IDLE;
    endcase
    if (instr_end) begin
      instr_done = 1'b1;
      if (step_mode || !RUN) begin
        state_n     = S_IDLE;
        step_mode_n = 1'b0;
      end else begin
        state_n = S_FETCH;
      end
    end
  end

  assign FETCH   = (state == S_FETCH);
  assign EXEC1   = (state == S_EXEC1);
  assign EXEC2   = (state == S_EXEC2);
  assign HALTED  = (state == S_IDLE) || (state == S_STOP);
  assign STOPPED = (state == S_STOP);
  assign BP_HIT  = bp_hit;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CLR_CNT),
    .inc   (FETCH | EXEC1 | EXEC2),
    .q     (CYCLE_CNT)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CLR_CNT),
    .inc   (instr_done),
    .q     (INSTR_CNT)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed and randomized bench for cpu_sequencer against an instruction-level model
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  localparam int PW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          RUN = 1'b0, STEP = 1'b0, EXTRA = 1'b0, BP_EN = 1'b0, CLR_CNT = 1'b0;
  logic [3:0]    IR = '0;
  logic [PW-1:0] PC = '0, BP_ADDR = '0;
  logic          FETCH, EXEC1, EXEC2, HALTED, STOPPED, BP_HIT;
  logic [CW-1:0] CYCLE_CNT, INSTR_CNT;

  cpu_sequencer #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .RUN(RUN), .STEP(STEP), .EXTRA(EXTRA), .IR(IR), .PC(PC),
    .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .CLR_CNT(CLR_CNT),
    .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .HALTED(HALTED), .STOPPED(STOPPED),
    .BP_HIT(BP_HIT), .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Program memory seen by the sequencer: opcode and EXTRA per PC
  logic [3:0] prog_ir [256];
  logic       prog_ex [256];

  // Reference model: remaining phases of the current instruction (1=FETCH, 2=EXEC1, 3=EXEC2)
  byte           phase_q[$];
  int            end_kind;  // 0 normal completion, 1 breakpoint abort, 2 STP
  bit            m_stop, m_bp, m_step_mode, m_req, m_sprev;
  int            m_cyc, m_ins;
  logic [PW-1:0] m_pc;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase_q.delete();
    end_kind    = 0;
    m_stop      = 0;
    m_bp        = 0;
    m_step_mode = 0;
    m_req       = 0;
    m_sprev     = 0;
    m_cyc       = 0;
    m_ins       = 0;
    m_pc        = '0;
  endtask

  // Plan the whole phase list of the instruction at m_pc
  task automatic start_instr(input bit resumed);
    phase_q.delete();
    phase_q.push_back(8'd1);
    if (BP_EN && (m_pc == BP_ADDR) && !resumed) begin
      end_kind = 1;
    end else begin
      phase_q.push_back(8'd2);
      if (prog_ir[m_pc] == OP_STP) begin
        end_kind = 2;
      end else begin
        end_kind = 0;
        if (prog_ex[m_pc]) phase_q.push_back(8'd3);
      end
    end
  endtask

  task automatic model_edge();
    bit req_now, active, done;
    req_now = m_req;
    m_req   = STEP && !m_sprev;
    m_sprev = STEP;
    active  = (phase_q.size() > 0);
    done    = 0;
    if (active) begin
      void'(phase_q.pop_front());
      if (phase_q.size() == 0) begin
        case (end_kind)
          1: m_bp = 1;
          2: begin m_stop = 1; done = 1; end
          default: begin
            done = 1;
            m_pc = m_pc + 1'b1;
            if (m_step_mode || !RUN) m_step_mode = 0;
            else start_instr(1'b0);
          end
        endcase
      end
    end else if (!m_stop && (RUN || req_now)) begin
      if (!RUN) m_step_mode = 1;
      m_bp = 0;
      start_instr(1'b1);
    end
    if (CLR_CNT) begin
      m_cyc = 0;
      m_ins = 0;
    end else begin
      if (active) m_cyc = sat(m_cyc + 1);
      if (done) m_ins = sat(m_ins + 1);
    end
  endtask

  task automatic drive_cpu();
    PC    = m_pc;
    IR    = prog_ir[m_pc];
    EXTRA = prog_ex[m_pc];
  endtask

  task automatic check_all();
    byte ph;
    ph = (phase_q.size() > 0) ? phase_q[0] : 8'd0;
    check("FETCH", FETCH, ph == 8'd1);
    check("EXEC1", EXEC1, ph == 8'd2);
    check("EXEC2", EXEC2, ph == 8'd3);
    check("HALTED", HALTED, phase_q.size() == 0);
    check("STOPPED", STOPPED, m_stop);
    check("BP_HIT", BP_HIT, m_bp);
    check("CYCLE_CNT", CYCLE_CNT, m_cyc);
    check("INSTR_CNT", INSTR_CNT, m_ins);
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic tick(input bit chk);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    drive_cpu();
    if (chk) check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive_cpu();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_prog(input logic [3:0] op, input logic ex);
    for (int i = 0; i < 256; i++) begin
      prog_ir[i] = op;
      prog_ex[i] = ex;
    end
  endtask

  initial begin
    bit found;

    // Free-running 2-cycle instructions
    fill_prog(4'h1, 1'b0);
    do_reset();
    RUN = 1'b1;
    repeat (9) tick(1'b1);
    check("t1_cycles", CYCLE_CNT, 8);
    check("t1_instr", INSTR_CNT, 4);
    RUN = 1'b0;
    repeat (4) tick(1'b1);
    check("t1_halted", HALTED, 1);

    // Single step of a 3-cycle instruction
    fill_prog(4'h2, 1'b1);
    do_reset();
    STEP = 1'b1;
    tick(1'b1);
    check("t2_no_early_fetch", FETCH, 0);
    tick(1'b1);
    check("t2_fetch_latency", FETCH, 1);
    STEP = 1'b0;
    repeat (6) tick(1'b1);
    check("t2_cycles", CYCLE_CNT, 3);
    check("t2_instr", INSTR_CNT, 1);
    check("t2_halted", HALTED, 1);

    // Breakpoint at PC 5, then resume without re-tripping
    fill_prog(4'h1, 1'b0);
    BP_EN = 1'b1;
    BP_ADDR = 8'd5;
    do_reset();
    RUN = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1'b1);
      if (m_bp && phase_q.size() == 0) found = 1;
    end
    check("t3_bp_reached", found, 1);
    check("t3_bp_hit", BP_HIT, 1);
    check("t3_bp_halted", HALTED, 1);
    check("t3_bp_no_exec1", EXEC1, 0);
    RUN = 1'b0;
    repeat (3) tick(1'b1);
    check("t3_still_halted", HALTED, 1);
    RUN = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick(1'b1);
      if (m_pc == 8'd6) found = 1;
    end
    check("t3_resumed", found, 1);
    check("t3_bp_cleared", BP_HIT, 0);
    check("t3_instr", INSTR_CNT, 6);
    RUN = 1'b0;
    BP_EN = 1'b0;
    repeat (4) tick(1'b1);

    // STP at PC 2 is absorbing
    fill_prog(4'h1, 1'b0);
    prog_ir[2] = OP_STP;
    do_reset();
    RUN = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1'b1);
      if (m_stop) found = 1;
    end
    check("t4_stop_reached", found, 1);
    check("t4_stopped", STOPPED, 1);
    check("t4_halted", HALTED, 1);
    check("t4_instr", INSTR_CNT, 3);
    for (int k = 0; k < 20; k++) begin
      RUN  = 1'($urandom_range(0, 1));
      STEP = 1'($urandom_range(0, 1));
      tick(1'b1);
      check("t4_no_phase", {FETCH, EXEC1, EXEC2}, 0);
    end
    RUN  = 1'b0;
    STEP = 1'b0;

    // Asynchronous reset during EXEC2
    fill_prog(4'h1, 1'b1);
    do_reset();
    RUN = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick(1'b1);
      if (phase_q.size() > 0 && phase_q[0] == 8'd3) found = 1;
    end
    check("t5_in_exec2", found, 1);
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_phases", {FETCH, EXEC1, EXEC2}, 0);
    check("t5_cycles", CYCLE_CNT, 0);
    check("t5_instr", INSTR_CNT, 0);
    check("t5_halted", HALTED, 1);
    RUN = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive_cpu();

    // Counter saturation and clear priority
    fill_prog(4'h1, 1'b0);
    do_reset();
    RUN = 1'b1;
    repeat (65540) tick(1'b0);
    check_all();
    check("t6_sat", CYCLE_CNT, 16'hFFFF);
    CLR_CNT = 1'b1;
    tick(1'b1);
    check("t6_clr_cycles", CYCLE_CNT, 0);
    check("t6_clr_instr", INSTR_CNT, 0);
    CLR_CNT = 1'b0;
    tick(1'b1);
    check("t6_after_clr", CYCLE_CNT, 1);
    RUN = 1'b0;
    repeat (4) tick(1'b1);

    // Randomized programs, run/step activity, breakpoints and clears
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 256; i++) begin
        prog_ir[i] = 4'($urandom_range(0, 15));
        if (prog_ir[i] == OP_STP && $urandom_range(0, 3) != 0) prog_ir[i] = 4'h0;
        prog_ex[i] = 1'($urandom_range(0, 1));
      end
      BP_EN   = 1'($urandom_range(0, 1));
      BP_ADDR = 8'($urandom_range(0, 40));
      do_reset();
      for (int k = 0; k < 500; k++) begin
        if ($urandom_range(0, 9) == 0) RUN = ~RUN;
        STEP    = ($urandom_range(0, 3) == 0);
        CLR_CNT = ($urandom_range(0, 63) == 0);
        tick(1'b1);
        if (m_stop && $urandom_range(0, 19) == 0) do_reset();
      end
      CLR_CNT = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
